// File: rtl/conversor_sar.sv
// -----------------------------------------------------------------------------
// conversor_sar
// Successive-approximation controller for the irrigation humidity front end.
// Drives a trial word into the magnitude comparator's `a` input. It reads back
// the three relation flags and uses them to rebuild the unknown level on the
// comparator's `b` input, one bit per trial, from the MSB down to the LSB.
// A trial that compares equal ends the conversion early.
//
// Parameters
//   WIDTH   : width of the trial and result words (must match the comparator)
//   ESPERA  : extra settle cycles each trial is held before the flags are
//             sampled (0..7)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   iniciar    in   start request, only honoured while idle
//   aIGUALb    in   comparator flag: trial == level
//   aMAIORb    in   comparator flag: trial >  level
//   aMENORb    in   comparator flag: trial <  level
//   tentativa  out  trial word driven to comparator input `a`
//   resultado  out  last successfully converted level (held between runs)
//   pronto     out  one-cycle pulse when resultado is updated
//   ocupado    out  high while a conversion is in progress
//   erro       out  sticky invalid-flag indication, cleared by the next start
// -----------------------------------------------------------------------------
module conversor_sar #(
    parameter int WIDTH  = 4,
    parameter int ESPERA = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iniciar,
    input  logic             aIGUALb,
    input  logic             aMAIORb,
    input  logic             aMENORb,
    output logic [WIDTH-1:0] tentativa,
    output logic [WIDTH-1:0] resultado,
    output logic             pronto,
    output logic             ocupado,
    output logic             erro
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        OCIOSO,
        ASSENTAR,
        TESTE
    } estado_t;

    estado_t            estado_q, estado_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   tentativa_q, tentativa_d;
    logic [WIDTH-1:0]   resultado_q, resultado_d;
    logic               pronto_q, pronto_d;
    logic               ocupado_q, ocupado_d;
    logic               erro_q, erro_d;

    logic               flags_validos;
    logic               bit_decidido;

    // Exactly one relation flag must be set; anything else is a broken
    // comparator or wiring fault. When valid and not equal, "trial below
    // level" means the bit under test belongs in the result.
    assign flags_validos = ({aIGUALb, aMAIORb, aMENORb} == 3'b100) ||
                           ({aIGUALb, aMAIORb, aMENORb} == 3'b010) ||
                           ({aIGUALb, aMAIORb, aMENORb} == 3'b001);
    assign bit_decidido  = aMENORb;

    // Next-state logic for the whole controller. All outputs come from the
    // registers below, so every output change lands on a clock edge.
    always_comb begin
        estado_d    = estado_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        tentativa_d = tentativa_q;
        resultado_d = resultado_q;
        pronto_d    = 1'b0;
        ocupado_d   = ocupado_q;
        erro_d      = erro_q;

        case (estado_q)
            OCIOSO: begin
                ocupado_d = 1'b0;
                if (iniciar) begin
                    tentativa_d            = '0;
                    tentativa_d[WIDTH-1]   = 1'b1;
                    idx_d                  = IDX_W'(WIDTH - 1);
                    erro_d                 = 1'b0;
                    ocupado_d              = 1'b1;
                    cnt_d                  = 3'(ESPERA);
                    estado_d               = (ESPERA > 0) ? ASSENTAR : TESTE;
                end
            end

            // The counter is loaded with ESPERA, so leaving on the cycle it
            // reads 1 gives exactly ESPERA cycles of settling per trial.
            ASSENTAR: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    estado_d = TESTE;
                end
            end

            TESTE: begin
                if (!flags_validos) begin
                    erro_d      = 1'b1;
                    ocupado_d   = 1'b0;
                    tentativa_d = '0;
                    estado_d    = OCIOSO;
                end else if (aIGUALb) begin
                    resultado_d = tentativa_q;
                    pronto_d    = 1'b1;
                    ocupado_d   = 1'b0;
                    tentativa_d = '0;
                    estado_d    = OCIOSO;
                end else if (idx_q == '0) begin
                    resultado_d    = tentativa_q;
                    resultado_d[0] = bit_decidido;
                    pronto_d       = 1'b1;
                    ocupado_d      = 1'b0;
                    tentativa_d    = '0;
                    estado_d       = OCIOSO;
                end else begin
                    // Settle the current bit and put the next lower bit on trial.
                    tentativa_d[idx_q]                = bit_decidido;
                    tentativa_d[idx_q - IDX_W'(1)]    = 1'b1;
                    idx_d                             = idx_q - IDX_W'(1);
                    cnt_d                             = 3'(ESPERA);
                    estado_d                          = (ESPERA > 0) ? ASSENTAR : TESTE;
                end
            end

            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // State and output registers; reset drops everything immediately and
    // discards any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= OCIOSO;
            idx_q       <= IDX_W'(WIDTH - 1);
            cnt_q       <= 3'd0;
            tentativa_q <= '0;
            resultado_q <= '0;
            pronto_q    <= 1'b0;
            ocupado_q   <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            tentativa_q <= tentativa_d;
            resultado_q <= resultado_d;
            pronto_q    <= pronto_d;
            ocupado_q   <= ocupado_d;
            erro_q      <= erro_d;
        end
    end

    assign tentativa = tentativa_q;
    assign resultado = resultado_q;
    assign pronto    = pronto_q;
    assign ocupado   = ocupado_q;
    assign erro      = erro_q;

endmodule

// File: tb/tb_conversor_sar.sv
// -----------------------------------------------------------------------------
// tb_conversor_sar
// Directed bench for conversor_sar. Two instances are used: one with no settle
// cycles and one with ESPERA=2. Each has its own behavioural comparator that
// produces the flags from the trial word and a bench-chosen level. Expected
// trial sequences and results are worked out by hand from the level.
// -----------------------------------------------------------------------------
module tb_conversor_sar;

    logic       clk;
    logic       rst_n;

    logic       iniciar0, iniciar2;
    logic [3:0] level0, level2;
    logic       force_both;

    logic       igual0, maior0, menor0;
    logic       igual2, maior2, menor2;
    logic [3:0] tent0, res0, tent2, res2;
    logic       pronto0, ocupado0, erro0;
    logic       pronto2, ocupado2, erro2;

    int compared;
    int mismatched;

    conversor_sar #(.WIDTH(4), .ESPERA(0)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .iniciar   (iniciar0),
        .aIGUALb   (igual0),
        .aMAIORb   (maior0),
        .aMENORb   (menor0),
        .tentativa (tent0),
        .resultado (res0),
        .pronto    (pronto0),
        .ocupado   (ocupado0),
        .erro      (erro0)
    );

    conversor_sar #(.WIDTH(4), .ESPERA(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .iniciar   (iniciar2),
        .aIGUALb   (igual2),
        .aMAIORb   (maior2),
        .aMENORb   (menor2),
        .tentativa (tent2),
        .resultado (res2),
        .pronto    (pronto2),
        .ocupado   (ocupado2),
        .erro      (erro2)
    );

    // Behavioural comparators; force_both injects an invalid flag pattern.
    always_comb begin
        igual0 = force_both ? 1'b0 : (tent0 == level0);
        maior0 = force_both ? 1'b1 : (tent0 >  level0);
        menor0 = force_both ? 1'b1 : (tent0 <  level0);
        igual2 = (tent2 == level2);
        maior2 = (tent2 >  level2);
        menor2 = (tent2 <  level2);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start request for one edge on the selected instance.
    task automatic applyStimulus(input bit sel, input logic [3:0] lvl);
        if (sel) begin
            level2   = lvl;
            iniciar2 = 1'b1;
        end else begin
            level0   = lvl;
            iniciar0 = 1'b1;
        end
        tick();
        iniciar0 = 1'b0;
        iniciar2 = 1'b0;
    endtask

    // Walk a conversion trial by trial: each trial must be held 'hold' cycles,
    // then pronto must appear with the given result. pulse_at >= 0 raises
    // iniciar during that trial to prove it is ignored.
    task automatic checkConv(input bit sel, input string tag, input int k,
                             input logic [3:0] t0, input logic [3:0] t1,
                             input logic [3:0] t2, input logic [3:0] t3,
                             input int hold, input logic [3:0] res,
                             input int pulse_at);
        logic [3:0] trials [4];
        trials[0] = t0;
        trials[1] = t1;
        trials[2] = t2;
        trials[3] = t3;
        for (int i = 0; i < k; i++) begin
            for (int h = 0; h < hold; h++) begin
                checkOutput($sformatf("%s_trial%0d_h%0d", tag, i, h),
                            32'(sel ? tent2 : tent0), 32'(trials[i]));
                checkOutput($sformatf("%s_busy%0d_h%0d", tag, i, h),
                            32'(sel ? ocupado2 : ocupado0), 32'd1);
                checkOutput($sformatf("%s_nopronto%0d_h%0d", tag, i, h),
                            32'(sel ? pronto2 : pronto0), 32'd0);
                if (i == pulse_at && h == 0) begin
                    if (sel) iniciar2 = 1'b1; else iniciar0 = 1'b1;
                end
                tick();
                iniciar0 = 1'b0;
                iniciar2 = 1'b0;
            end
        end
        checkOutput({tag, "_pronto"},    32'(sel ? pronto2  : pronto0),  32'd1);
        checkOutput({tag, "_resultado"}, 32'(sel ? res2     : res0),     32'(res));
        checkOutput({tag, "_idle"},      32'(sel ? ocupado2 : ocupado0), 32'd0);
        checkOutput({tag, "_tent0"},     32'(sel ? tent2    : tent0),    32'd0);
        tick();
        checkOutput({tag, "_pulse"},     32'(sel ? pronto2  : pronto0),  32'd0);
        checkOutput({tag, "_norestart"}, 32'(sel ? ocupado2 : ocupado0), 32'd0);
        checkOutput({tag, "_reshold"},   32'(sel ? res2     : res0),     32'(res));
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        iniciar0   = 1'b0;
        iniciar2   = 1'b0;
        level0     = 4'd0;
        level2     = 4'd0;
        force_both = 1'b0;
        rst_n      = 1'b0;

        #2;
        checkOutput("rst_tent",    32'(tent0),    32'd0);
        checkOutput("rst_res",     32'(res0),     32'd0);
        checkOutput("rst_pronto",  32'(pronto0),  32'd0);
        checkOutput("rst_ocupado", 32'(ocupado0), 32'd0);
        checkOutput("rst_erro",    32'(erro0),    32'd0);
        checkOutput("rst_tent2",   32'(tent2),    32'd0);
        #10;
        rst_n = 1'b1;
        tick();
        tick();
        checkOutput("idle_ocupado", 32'(ocupado0), 32'd0);

        // Level 9: 8<9 keep, 12>9 drop, 10>9 drop, 9 equal.
        applyStimulus(1'b0, 4'd9);
        checkConv(1'b0, "lvl9", 4, 4'd8, 4'd12, 4'd10, 4'd9, 1, 4'd9, -1);

        // Level 0: every trial above, LSB decided as 0.
        applyStimulus(1'b0, 4'd0);
        checkConv(1'b0, "lvl0", 4, 4'd8, 4'd4, 4'd2, 4'd1, 1, 4'd0, -1);

        // Level 15: every trial below until 15 is equal.
        applyStimulus(1'b0, 4'd15);
        checkConv(1'b0, "lvl15", 4, 4'd8, 4'd12, 4'd14, 4'd15, 1, 4'd15, -1);

        // Level 8: first trial equal, pronto on the next edge.
        applyStimulus(1'b0, 4'd8);
        checkConv(1'b0, "lvl8", 1, 4'd8, 4'd0, 4'd0, 4'd0, 1, 4'd8, -1);

        // ESPERA=2, level 5: 8,4,6,5 each held three cycles.
        applyStimulus(1'b1, 4'd5);
        checkConv(1'b1, "esp2_lvl5", 4, 4'd8, 4'd4, 4'd6, 4'd5, 3, 4'd5, -1);

        // Invalid flags during the second trial.
        applyStimulus(1'b0, 4'd9);
        checkOutput("err_trial0", 32'(tent0), 32'd8);
        tick();
        checkOutput("err_trial1", 32'(tent0), 32'd12);
        force_both = 1'b1;
        tick();
        force_both = 1'b0;
        checkOutput("err_erro",    32'(erro0),    32'd1);
        checkOutput("err_ocupado", 32'(ocupado0), 32'd0);
        checkOutput("err_pronto",  32'(pronto0),  32'd0);
        checkOutput("err_res",     32'(res0),     32'd8);
        checkOutput("err_tent",    32'(tent0),    32'd0);
        tick();
        checkOutput("err_sticky",  32'(erro0),    32'd1);
        applyStimulus(1'b0, 4'd5);
        checkOutput("err_cleared", 32'(erro0),    32'd0);
        checkConv(1'b0, "after_err", 4, 4'd8, 4'd4, 4'd6, 4'd5, 1, 4'd5, -1);

        // Start request during a running conversion is ignored.
        applyStimulus(1'b0, 4'd9);
        checkConv(1'b0, "busy_ini", 4, 4'd8, 4'd12, 4'd10, 4'd9, 1, 4'd9, 1);

        // Asynchronous reset during the third trial.
        applyStimulus(1'b0, 4'd9);
        tick();
        tick();
        checkOutput("mid_trial2", 32'(tent0), 32'd10);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_tent",    32'(tent0),    32'd0);
        checkOutput("mid_rst_res",     32'(res0),     32'd0);
        checkOutput("mid_rst_ocupado", 32'(ocupado0), 32'd0);
        checkOutput("mid_rst_pronto",  32'(pronto0),  32'd0);
        checkOutput("mid_rst_res2",    32'(res2),     32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        // Level 3: 8>3, 4>3, 2<3 keep, 3 equal.
        applyStimulus(1'b0, 4'd3);
        checkConv(1'b0, "post_rst_lvl3", 4, 4'd8, 4'd4, 4'd2, 4'd3, 1, 4'd3, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
